interval_timer_arbiter: RTL and testbench
=========================================

// Module: interval_timer_arbiter
// PURPOSE
//  Shares one interval counter (count 0..N, terminal-count flag) between NUM_REQ requesters.
//  Each requester asks for a delay of req_len+1 RUN cycles. The block grants the counter
//  round-robin, runs it, and pulses done to the owner at terminal count.
//  Sits between control FSMs needing timed waits and a single counter resource.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  CNT_W    7  counter/length width; max interval 2^CNT_W cycles (default 0..127)
// PORTS
//  sys_clk   in   1              system clock, all logic on rising edge
//  sys_rst   in   1              synchronous reset, active-high
//  req       in   NUM_REQ        per-requester request level; held until done
//  req_len   in   NUM_REQ*CNT_W  packed lengths; slice i = req_len[i*CNT_W +: CNT_W]
//  grant     out  NUM_REQ        one-hot owner of the counter; zero when idle
//  done      out  NUM_REQ        one-cycle pulse to owner at terminal count
//  busy      out  1              high while in RUN
//  cnt_dbg   out  CNT_W          current counter value (0 when idle)
// BEHAVIOUR
//  - One clock and one reset. Reset is synchronous and active-high. Reset wins over all other inputs.
//  - Reset values: grant=0, done=0, busy=0, cnt_dbg=0, state=IDLE, rr pointer=0 (requester 0 highest).
//  - FSM has 2 states:
//    IDLE: if any req, pick the first set bit at or after ptr, wrapping round.
//      On the next edge: latch len_q=req_len[sel], set cnt=0, set grant=onehot(sel), go to RUN.
//      No req: stay in IDLE.
//    RUN: each cycle, cnt<=cnt+1.
//      done[sel]=1 combinationally while cnt==len_q. Next edge: state=IDLE, grant=0,
//      cnt=0, ptr=(sel+1) mod NUM_REQ.
//  - Interval: RUN lasts len_q+1 cycles.
//    Req first seen high in IDLE at cycle 0 -> grant from cycle 1 -> done in cycle 1+len_q.
//  - len=0: done in the first RUN cycle. Counter never wraps past len_q.
//    len_q is stable for the whole grant; req_len changes during RUN are ignored.
//  - Abort: owner's req low during RUN -> IDLE on the next edge, no done, ptr advances past sel.
//    If req drops in the same cycle as cnt==len_q, done still pulses.
//  - req is sampled only in IDLE. Between grants there is always one IDLE cycle (no back-to-back RUN).
//  - Requester still high after its done: re-arbitrated in IDLE with lowest priority (fairness).
//  - Non-owner req changes during RUN have no effect until IDLE.
//  - Reset mid-RUN: next cycle all outputs are at reset values, no done is emitted, ptr=0.
//  - Invariants: grant is one-hot-or-zero; done is a subset of grant;
//    busy==|grant; at most one done bit per cycle.
// STRUCTURE
//  - Shared package timer_arb_pkg: state encodings ST_IDLE/ST_RUN, defaults for NUM_REQ/CNT_W,
//    helper function onehot(idx).
//  - One sub-module: rr_arbiter (req vector + ptr -> sel index + valid, combinational).
//    The FSM, len_q, cnt and ptr registers stay in interval_timer_arbiter.
//  - The counter is internal; the terminal-count compare is cnt==len_q, not a fixed constant.
// TESTING
//  1. Single requester: req=4'b0001, len0=99 -> grant=0001 cycles 1..100, done[0] in cycle 100
//     only, cnt_dbg=99 there, IDLE at cycle 101.
//  2. Simultaneous: req=0101 at cycle 0, len0=2, len2=3, both held -> grant 0001 cycles 1..3,
//     IDLE at cycle 4, grant 0100 cycles 5..8, done[2] in cycle 8.
//  3. Fairness: req=1111 held, all len=0 -> grant sequence 0001,0010,0100,1000,0001,
//     one grant every 2 cycles.
//  4. Abort: req0 len=10, drop req0 at cycle 5 -> grant 0 at cycle 6, no done[0],
//     waiting req1 granted at cycle 7.
//  5. Reset mid-run: sys_rst high for 1 cycle at cnt=50 -> next cycle grant=0, busy=0,
//     cnt_dbg=0, no done; req0 regranted 2 cycles after reset release.
//  6. Edge values: len=0 -> done in the first RUN cycle; len=127 -> done at cnt=127,
//     no wrap; req_len changed mid-RUN -> interval unchanged.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// Shared definitions for the interval timer arbiter: FSM encoding, default sizes
// and the one-hot helper used to build the grant vector.
package timer_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 7;
    localparam int MAX_REQ     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/interval_timer_arbiter.sv
// One interval counter shared round-robin between NUM_REQ requesters; the owner
// gets len+1 RUN cycles and a done pulse on the last one.
module interval_timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt_dbg
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] arb_sel;
    logic             arb_valid;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic             terminal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    assign terminal = (cnt == len_q);

    // Terminal count is compared against the latched length, so the counter stops at len_q.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            grant <= '0;
            cnt   <= '0;
            len_q <= '0;
            sel_q <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state <= ST_RUN;
                        sel_q <= arb_sel;
                        len_q <= req_len[arb_sel*CNT_W +: CNT_W];
                        cnt   <= '0;
                        grant <= NUM_REQ'(onehot(3'(arb_sel)));
                    end
                end
                ST_RUN: begin
                    // Abort or completion both release the counter and rotate priority.
                    if (terminal || !req[sel_q]) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        cnt   <= '0;
                        ptr   <= (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done    = (state == ST_RUN && terminal) ? grant : '0;
    assign busy    = (state == ST_RUN);
    assign cnt_dbg = cnt;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Randomized and directed checks of interval_timer_arbiter against a cycle-level
// ownership model (owner index, elapsed count, length, rotation pointer).
module tb_interval_timer_arbiter;

    localparam int N = 4;
    localparam int W = 7;
    localparam int VW = 2*N + 1 + W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cnt_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner = -1;
    int m_cnt   = 0;
    int m_len   = 0;
    int m_ptr   = 0;

    interval_timer_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .req     (req),
        .req_len (req_len),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .cnt_dbg (cnt_dbg)
    );

    always #5 clk = ~clk;

    function automatic int len_of(int i);
        return int'(req_len[i*W +: W]);
    endfunction

    task automatic set_len(int i, int v);
        req_len[i*W +: W] = W'(v);
    endtask

    // Ownership model: who holds the counter, how long, and who is next in line.
    task automatic model_edge();
        int c;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_len = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (req[c]) begin
                    m_owner = c; m_len = len_of(c); m_cnt = 0;
                    break;
                end
            end
        end else if (m_cnt == m_len || !req[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g, d;
        logic         b;
        logic [W-1:0] c;
        g = '0; d = '0; b = 1'b0; c = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            b = 1'b1;
            c = W'(m_cnt);
            if (m_cnt == m_len) d = g;
        end
        return {g, d, b, c};
    endfunction

    // Advance one clock; inputs change only at negedge, outputs are observed at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1011; set_len(0, 3);
        rst = 1'b1;
        step(); step();
        n_checks++;
        if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || cnt_dbg !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state got g=%b d=%b b=%b c=%0d want all zero", grant, done, busy, cnt_dbg);
        end
        req = '0; rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_len(0, 99); req = 4'b0001;
        for (int cyc = 1; cyc <= 102; cyc++) begin
            step();
            n_checks++;
            if ({grant, done, busy, cnt_dbg} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model cyc %0d got %h want %h", cyc, {grant, done, busy, cnt_dbg}, exp_vec());
            end
            if (cyc == 100) begin
                n_checks++;
                if (done !== 4'b0001 || cnt_dbg !== 7'd99 || grant !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL single_term cyc 100 got d=%b c=%0d g=%b want d=0001 c=99 g=0001", done, cnt_dbg, grant);
                end
                req = '0;
            end
            if (cyc == 101) begin
                n_checks++;
                if (busy !== 1'b0 || grant !== 4'b0) begin
                    n_fail++;
                    $display("FAIL single_idle cyc 101 got b=%b g=%b want b=0 g=0000", busy, grant);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] gtbl [9];
        gtbl = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        do_reset();
        set_len(0, 2); set_len(2, 3); req = 4'b0101;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            step();
            n_checks++;
            if (grant !== gtbl[cyc-1] || done[2] !== (cyc == 8) || {grant, done, busy, cnt_dbg} !== exp_vec()) begin
                n_fail++;
                $display("FAIL simult cyc %0d got g=%b d=%b want g=%b d2=%0d", cyc, grant, done, gtbl[cyc-1], (cyc == 8));
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] ftbl [5];
        logic [N-1:0] want;
        ftbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 0);
        req = 4'b1111;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            want = (cyc % 2 == 1) ? ftbl[(cyc-1)/2] : 4'b0000;
            n_checks++;
            if (grant !== want || done !== want) begin
                n_fail++;
                $display("FAIL fairness cyc %0d got g=%b d=%b want g=%b d=%b", cyc, grant, done, want, want);
            end
        end
        req = '0;
    endtask

    task automatic test_abort();
        logic seen_done0;
        seen_done0 = 1'b0;
        do_reset();
        set_len(0, 10); set_len(1, 5); req = 4'b0011;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            step();
            if (done[0]) seen_done0 = 1'b1;
            n_checks++;
            if ({grant, done, busy, cnt_dbg} !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort_model cyc %0d got %h want %h", cyc, {grant, done, busy, cnt_dbg}, exp_vec());
            end
            if (cyc == 5) req[0] = 1'b0;
            if (cyc == 6 || cyc == 7) begin
                n_checks++;
                if (grant !== ((cyc == 6) ? 4'b0000 : 4'b0010)) begin
                    n_fail++;
                    $display("FAIL abort_grant cyc %0d got %b want %b", cyc, grant, (cyc == 6) ? 4'b0000 : 4'b0010);
                end
            end
        end
        n_checks++;
        if (seen_done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nodone got done0_seen=%b want 0", seen_done0);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_len(0, 100); req = 4'b0001;
        for (int cyc = 1; cyc <= 51; cyc++) step();
        n_checks++;
        if (cnt_dbg !== 7'd50 || grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_pre got c=%0d g=%b want c=50 g=0001", cnt_dbg, grant);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || cnt_dbg !== 7'd0 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got g=%b b=%b c=%0d d=%b want zeros", grant, busy, cnt_dbg, done);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0001 || cnt_dbg !== 7'd0 || {grant, done, busy, cnt_dbg} !== exp_vec()) begin
            n_fail++;
            $display("FAIL rstmid_regrant got g=%b c=%0d want g=0001 c=0", grant, cnt_dbg);
        end
        req = '0;
    endtask

    task automatic test_edges();
        do_reset();
        set_len(1, 0); req = 4'b0010;
        step();
        n_checks++;
        if (done !== 4'b0010 || grant !== 4'b0010 || cnt_dbg !== 7'd0) begin
            n_fail++;
            $display("FAIL len0 got d=%b g=%b c=%0d want d=0010 g=0010 c=0", done, grant, cnt_dbg);
        end
        req = '0;
        do_reset();
        set_len(3, 127); req = 4'b1000;
        for (int cyc = 1; cyc <= 129; cyc++) begin
            step();
            if (cyc == 3) set_len(3, 5);
            n_checks++;
            if (cyc <= 128 && (done !== ((cyc == 128) ? 4'b1000 : 4'b0000) || cnt_dbg !== W'(cyc - 1))) begin
                n_fail++;
                $display("FAIL len127 cyc %0d got d=%b c=%0d want d=%b c=%0d", cyc, done, cnt_dbg,
                         (cyc == 128) ? 4'b1000 : 4'b0000, cyc - 1);
            end else if (cyc == 129 && (busy !== 1'b0 || cnt_dbg !== 7'd0)) begin
                n_fail++;
                $display("FAIL len127_nowrap got b=%b c=%0d want b=0 c=0", busy, cnt_dbg);
            end
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) set_len(i, $urandom_range(0, 12));
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            n_checks++;
            if ({grant, done, busy, cnt_dbg} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cyc %0d got %h want %h", cyc, {grant, done, busy, cnt_dbg}, exp_vec());
            end
            n_checks++;
            if (!$onehot0(grant) || (done & ~grant) != '0 || busy !== (|grant) || !$onehot0(done)) begin
                n_fail++;
                $display("FAIL random_invariant cyc %0d got g=%b d=%b b=%b want onehot0, d in g, b=|g", cyc, grant, done, busy);
            end
        end
        rst = 1'b0; req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_abort();
        test_reset_mid();
        test_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
